pipe_fetch_stage: RTL and testbench
===================================

# pipe_fetch_stage

Instruction-fetch stage for the five-stage pipelined MIPS CPU. Owns the PC register, issues requests to a variable-latency instruction memory, and loads the IF/ID pipeline register consumed by the decode stage. Supports decode-stage stall, a one-entry skid buffer for responses that arrive during a stall, and MIPS branch-delay-slot redirects resolved in ID. Its `pc` output is the CPU-level `pc` probed by the top-level testbench.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- stall  in  1  ID hazard stall: hold IF/ID, ignore `redirect`.
- redirect  in  1  taken branch/jump in ID; single-cycle pulse, valid only when stall=0.
- redirect_pc  in  32  target; bits [1:0] forced to 0 internally.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_ack  in  1  response valid; transfer on any edge with imem_req & imem_ack.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- pc  out  32  current fetch PC.
- id_valid  out  1  IF/ID holds a real instruction.
- id_inst  out  32  IF/ID instruction.
- id_pc4  out  32  IF/ID PC+4.

## Operation
- States: FETCH (imem_req=1, skid empty), HOLD (imem_req=0, skid full). Plus flag redir_pend with 32-bit redir_tgt.
- imem_addr = pc; pc changes only on transfer or on redirect in HOLD, so address is stable while a request is outstanding.
- Transfer in FETCH: pc ← redir_tgt if (redirect | redir_pend), else pc+4 (mod 2^32); redir_pend ← 0. Transferred word is the delay slot when a redirect is active and is always delivered.
- Transfer with stall=1: word and pc+4 go to skid; state → HOLD.
- Redirect in FETCH without transfer: redir_pend ← 1, redir_tgt ← redirect_pc; the in-flight delay-slot fetch completes normally.
- Redirect in HOLD: skid already holds the delay slot; pc ← redirect_pc directly; no pending flag.
- Second redirect while redir_pend=1 (branch in delay slot, illegal): newer target overwrites.
- IF/ID update when stall=0: skid full → load skid, state → FETCH; else transfer this edge → load imem_rdata / pc+4; else bubble (id_valid ← 0, id_inst/id_pc4 hold). When stall=1: IF/ID holds.
- Reset: pc=RESET_PC, state=FETCH, imem_req=0 while reset asserted, id_valid=0, id_inst=0, id_pc4=0, skid empty, redir_pend=0. Reset mid-request abandons it; memory must tolerate req dropping.

## Timing
- Zero-wait memory (ack tied 1): one instruction per cycle; id_inst = mem[pc] one edge after pc presented.
- First edge after reset release: id_inst=mem[RESET_PC], id_pc4=RESET_PC+4, pc=RESET_PC+4.
- Redirect latency: target is fetched on the request immediately after the delay slot transfer.
- Skid drain: one edge after stall falls in HOLD, IF/ID = skid; fetch resumes same edge.
- No combinational path from imem_ack/imem_rdata to imem_req/imem_addr.

## Structure
- Shared include `pipe_defs.vh`: state encodings, RESET_PC default, NOP word (32'h0000_0000), INST_W=32.
- Sub-module `if_skid_buf`: one-entry buffer (data, pc4, full) with load/drain; reused by later stages.

## Test plan
- Reset, ack=1, mem[0..3]=0x20080005,0x20090003,0x01095020,0x00000000 -> id_inst sequence in order, id_pc4 = 4,8,12,16, pc increments by 4 per cycle.
- ack delayed 3 cycles per request -> imem_addr stable during wait, id_valid=0 bubbles between instructions, no duplicate/lost words.
- stall=1 for 4 cycles while response arrives at pc=0x8 -> state HOLD, imem_req=0, IF/ID unchanged; on release id_inst=mem[0x8], then mem[0xC] next.
- redirect to 0x40 while delay slot fetch at 0x10 pending 2 cycles -> id_inst=mem[0x10] then mem[0x40]; mem[0x14] never requested.
- redirect to 0x40 in HOLD with skid=mem[0x10] -> pc=0x40 immediately, IF/ID gets mem[0x10] then mem[0x40].
- reset asserted mid-request at pc=0x20 -> outputs instantly reset values; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipe_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fetch_stage_pkg
// Purpose  : Shared constants, state encoding and helpers for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_fetch_stage_pkg;

    localparam int unsigned c_inst_w   = 32;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_nop      = 32'h0000_0000;
    localparam logic [31:0] c_pc_step  = 32'd4;

    // FETCH: request outstanding, skid empty. HOLD: skid full, request parked.
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fetch_stage_if
// Purpose  : Instruction-memory request/response bus between fetch and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_fetch_stage_if;
    import pipe_fetch_stage_pkg::*;

    logic                req;
    logic [c_inst_w-1:0] addr;
    logic                ack;
    logic [c_inst_w-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/if_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_skid_buf
// Purpose  : One-entry skid buffer holding an instruction word and its PC+4.
// Revision : 1.0 - initial release
// ============================================================================
module if_skid_buf #(
    parameter int unsigned DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic              i_drain,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic [DATA_W-1:0] i_pc4,
    output logic                   o_full,
    output logic [DATA_W-1:0]      o_data,
    output logic [DATA_W-1:0]      o_pc4
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_pc4;

    // Contents are left in place on drain; only the full flag matters downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_pc4  <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_pc4  <= i_pc4;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
    assign o_pc4  = r_pc4;

endmodule
`default_nettype wire

// File: rtl/pipe_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fetch_stage
// Purpose  : MIPS IF stage: PC, variable-latency imem fetch, IF/ID register,
//            decode stall with skid buffer, delay-slot redirect handling.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_fetch_stage
    import pipe_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  wire logic                clock,
    input  wire logic                reset,
    input  wire logic                stall,
    input  wire logic                redirect,
    input  wire logic [31:0]         redirect_pc,
    pipe_fetch_stage_if.master       imem,
    output logic [31:0]              pc,
    output logic                     id_valid,
    output logic [c_inst_w-1:0]      id_inst,
    output logic [31:0]              id_pc4
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;

    logic                w_req;
    logic                w_xfer;
    logic                w_redir;
    logic                w_skid_load;
    logic                w_skid_drain;
    logic                w_skid_full;
    logic [31:0]         w_pc4;
    logic [31:0]         w_redir_pc;
    logic [31:0]         w_redir_sel;
    logic [c_inst_w-1:0] w_skid_data;
    logic [31:0]         w_skid_pc4;

    logic [31:0]         r_pc;
    logic                r_redir_pend;
    logic [31:0]         r_redir_tgt;
    logic                r_id_valid;
    logic [c_inst_w-1:0] r_id_inst;
    logic [31:0]         r_id_pc4;

    assign w_pc4       = r_pc + c_pc_step;
    assign w_redir     = redirect & ~stall;
    assign w_redir_pc  = align_word(redirect_pc);
    assign w_xfer      = w_req & imem.ack;
    // A live redirect carries the newest target; otherwise use the parked one.
    assign w_redir_sel = w_redir ? w_redir_pc : r_redir_tgt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req        = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_drain = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_req = ~reset;
                if (w_xfer && stall) begin
                    w_skid_load = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    w_skid_drain = 1'b1;
                    w_state_nxt  = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // PC only moves on a transfer or a HOLD redirect, keeping imem_addr stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_redir_tgt  <= RESET_PC;
        end else if (w_xfer) begin
            r_pc         <= (w_redir || r_redir_pend) ? w_redir_sel : w_pc4;
            r_redir_pend <= 1'b0;
        end else if (w_redir) begin
            if (r_state == ST_HOLD) begin
                r_pc <= w_redir_pc;
            end else begin
                r_redir_pend <= 1'b1;
                r_redir_tgt  <= w_redir_pc;
            end
        end
    end

    if_skid_buf #(
        .DATA_W (c_inst_w)
    ) u_skid (
        .clk     (clock),
        .rst     (reset),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_data  (imem.rdata),
        .i_pc4   (w_pc4),
        .o_full  (w_skid_full),
        .o_data  (w_skid_data),
        .o_pc4   (w_skid_pc4)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_id_valid <= 1'b0;
            r_id_inst  <= c_nop;
            r_id_pc4   <= '0;
        end else if (!stall) begin
            if (w_skid_full) begin
                r_id_valid <= 1'b1;
                r_id_inst  <= w_skid_data;
                r_id_pc4   <= w_skid_pc4;
            end else if (w_xfer) begin
                r_id_valid <= 1'b1;
                r_id_inst  <= imem.rdata;
                r_id_pc4   <= w_pc4;
            end else begin
                r_id_valid <= 1'b0;
            end
        end
    end

    assign imem.req  = w_req;
    assign imem.addr = r_pc;
    assign pc        = r_pc;
    assign id_valid  = r_id_valid;
    assign id_inst   = r_id_inst;
    assign id_pc4    = r_id_pc4;

endmodule
`default_nettype wire

// File: tb/tb_pipe_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_fetch_stage
// Purpose  : Directed self-checking bench for pipe_fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;

    int          errors = 0;
    int          checks = 0;
    int          lat = 0;
    int          cnt;
    logic        seen14 = 1'b0;
    logic [31:0] mem [0:255];
    logic [31:0] exp_inst [0:3];

    pipe_fetch_stage_if imem ();

    pipe_fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .pc          (pc),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc4      (id_pc4)
    );

    always #5 clock = ~clock;

    // Memory answers after lat wait cycles of an outstanding request.
    assign imem.ack   = imem.req && (cnt >= lat);
    assign imem.rdata = mem[imem.addr[9:2]];

    always @(posedge clock or posedge reset) begin
        if (reset)                      cnt <= 0;
        else if (imem.req && imem.ack)  cnt <= 0;
        else if (imem.req)              cnt <= cnt + 1;
    end

    always @(negedge clock) begin
        if (imem.req && imem.addr == 32'h14) seen14 = 1'b1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", pc, 32'h0); end
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem.req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", id_valid); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", id_inst); end
        checks++; if (id_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", id_pc4); end
    endtask

    task automatic test_zero_wait();
        lat = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL zw_valid k=%0d got %b exp 1", k, id_valid); end
            checks++; if (id_inst !== exp_inst[k]) begin errors++; $display("FAIL zw_inst k=%0d got %h exp %h", k, id_inst, exp_inst[k]); end
            checks++; if (id_pc4 !== 32'(4 * (k + 1))) begin errors++; $display("FAIL zw_pc4 k=%0d got %h exp %h", k, id_pc4, 32'(4 * (k + 1))); end
            checks++; if (pc !== 32'(4 * (k + 1))) begin errors++; $display("FAIL zw_pc k=%0d got %h exp %h", k, pc, 32'(4 * (k + 1))); end
        end
    endtask

    task automatic test_wait();
        lat = 3;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 3; w++) begin
                tick();
                checks++; if (imem.addr !== 32'(4 * k)) begin errors++; $display("FAIL wt_addr k=%0d w=%0d got %h exp %h", k, w, imem.addr, 32'(4 * k)); end
                checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL wt_req k=%0d w=%0d got %b exp 1", k, w, imem.req); end
                checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL wt_bubble k=%0d w=%0d got %b exp 0", k, w, id_valid); end
            end
            tick();
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL wt_valid k=%0d got %b exp 1", k, id_valid); end
            checks++; if (id_inst !== exp_inst[k]) begin errors++; $display("FAIL wt_inst k=%0d got %h exp %h", k, id_inst, exp_inst[k]); end
            checks++; if (id_pc4 !== 32'(4 * k + 4)) begin errors++; $display("FAIL wt_pc4 k=%0d got %h exp %h", k, id_pc4, 32'(4 * k + 4)); end
        end
    endtask

    task automatic test_stall();
        lat = 0;
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL st_req s=%0d got %b exp 0", s, imem.req); end
            checks++; if (id_inst !== 32'h2009_0003) begin errors++; $display("FAIL st_inst s=%0d got %h exp %h", s, id_inst, 32'h2009_0003); end
            checks++; if (id_pc4 !== 32'h8) begin errors++; $display("FAIL st_pc4 s=%0d got %h exp 8", s, id_pc4); end
            checks++; if (pc !== 32'hC) begin errors++; $display("FAIL st_pc s=%0d got %h exp c", s, pc); end
        end
        stall = 1'b0;
        tick();
        checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL st_resume_req got %b exp 1", imem.req); end
        checks++; if (id_inst !== 32'h0109_5020) begin errors++; $display("FAIL st_drain_inst got %h exp %h", id_inst, 32'h0109_5020); end
        checks++; if (id_pc4 !== 32'hC) begin errors++; $display("FAIL st_drain_pc4 got %h exp c", id_pc4); end
        tick();
        checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL st_next_inst got %h exp 0", id_inst); end
        checks++; if (id_pc4 !== 32'h10) begin errors++; $display("FAIL st_next_pc4 got %h exp 10", id_pc4); end
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL st_next_pc got %h exp 10", pc); end
    endtask

    task automatic test_redirect_pending();
        lat = 2;
        seen14 = 1'b0;
        do_reset();
        repeat (12) tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL rp_pre_pc got %h exp 10", pc); end
        checks++; if (id_pc4 !== 32'h10) begin errors++; $display("FAIL rp_pre_pc4 got %h exp 10", id_pc4); end
        redirect = 1'b1;
        redirect_pc = 32'h41;
        tick();
        redirect = 1'b0;
        redirect_pc = 32'h0;
        checks++; if (imem.addr !== 32'h10) begin errors++; $display("FAIL rp_addr_hold got %h exp 10", imem.addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rp_bubble got %b exp 0", id_valid); end
        tick();
        tick();
        checks++; if (id_inst !== 32'h1000_0004) begin errors++; $display("FAIL rp_slot_inst got %h exp %h", id_inst, 32'h1000_0004); end
        checks++; if (id_pc4 !== 32'h14) begin errors++; $display("FAIL rp_slot_pc4 got %h exp 14", id_pc4); end
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL rp_tgt_pc got %h exp 40", pc); end
        tick();
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rp_wait_bubble got %b exp 0", id_valid); end
        tick();
        checks++; if (id_inst !== 32'h1000_0010) begin errors++; $display("FAIL rp_tgt_inst got %h exp %h", id_inst, 32'h1000_0010); end
        checks++; if (id_pc4 !== 32'h44) begin errors++; $display("FAIL rp_tgt_pc4 got %h exp 44", id_pc4); end
        checks++; if (seen14 !== 1'b0) begin errors++; $display("FAIL rp_no_14 got %b exp 0", seen14); end
    endtask

    task automatic test_redirect_hold();
        lat = 0;
        seen14 = 1'b0;
        do_reset();
        repeat (4) tick();
        stall = 1'b1;
        tick();
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL rh_req got %b exp 0", imem.req); end
        checks++; if (id_pc4 !== 32'h10) begin errors++; $display("FAIL rh_hold_pc4 got %h exp 10", id_pc4); end
        tick();
        stall = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        redirect_pc = 32'h0;
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL rh_pc got %h exp 40", pc); end
        checks++; if (id_inst !== 32'h1000_0004) begin errors++; $display("FAIL rh_slot_inst got %h exp %h", id_inst, 32'h1000_0004); end
        checks++; if (id_pc4 !== 32'h14) begin errors++; $display("FAIL rh_slot_pc4 got %h exp 14", id_pc4); end
        tick();
        checks++; if (id_inst !== 32'h1000_0010) begin errors++; $display("FAIL rh_tgt_inst got %h exp %h", id_inst, 32'h1000_0010); end
        checks++; if (id_pc4 !== 32'h44) begin errors++; $display("FAIL rh_tgt_pc4 got %h exp 44", id_pc4); end
        checks++; if (seen14 !== 1'b0) begin errors++; $display("FAIL rh_no_14 got %b exp 0", seen14); end
    endtask

    task automatic test_reset_mid();
        lat = 0;
        do_reset();
        repeat (8) tick();
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL rm_pre_pc got %h exp 20", pc); end
        lat = 5;
        tick();
        checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL rm_pending_req got %b exp 1", imem.req); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rm_pc got %h exp 0", pc); end
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL rm_req got %b exp 0", imem.req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", id_valid); end
        checks++; if (id_inst !== 32'h0 || id_pc4 !== 32'h0) begin errors++; $display("FAIL rm_ifid got %h/%h exp 0/0", id_inst, id_pc4); end
        lat = 0;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (id_inst !== 32'h2008_0005) begin errors++; $display("FAIL rm_restart_inst got %h exp %h", id_inst, 32'h2008_0005); end
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL rm_restart_pc got %h exp 4", pc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'h0000_0000;
        exp_inst[0] = 32'h2008_0005;
        exp_inst[1] = 32'h2009_0003;
        exp_inst[2] = 32'h0109_5020;
        exp_inst[3] = 32'h0000_0000;

        test_reset();
        test_zero_wait();
        test_wait();
        test_stall();
        test_redirect_pending();
        test_redirect_hold();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
